// File: rtl/auth_cmd_tx.sv
// rtl/auth_cmd_tx.sv - 8N1 UART transmitter for go/stop authentication command bytes
module auth_cmd_tx #(
    parameter int          BAUD_DIV = 2604,
    parameter logic [7:0]  G_CMD    = 8'h47,
    parameter logic [7:0]  S_CMD    = 8'h53
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go_req,
    input  logic       stop_req,
    output logic       TX,
    output logic       tx_busy,
    output logic       cmd_done,
    output logic [7:0] last_cmd,
    output logic       pend_valid
);

    localparam int              CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    cur_byte;
    logic [7:0]    pend_byte;

    logic          req;
    logic [7:0]    req_byte;
    logic          bit_end;
    logic          load;
    logic [7:0]    load_byte;

    // Request decode: stop wins when both arrive together; bit boundary strobe
    always_comb begin
        req      = go_req | stop_req;
        req_byte = stop_req ? S_CMD : G_CMD;
        bit_end  = (baud_cnt == BAUD_LAST);
    end

    // Next-state, frame-load decision and line outputs
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_byte = req_byte;
        case (state)
            IDLE: begin
                if (req) begin
                    load      = 1'b1;
                    load_byte = req_byte;
                    state_nxt = START;
                end else if (pend_valid) begin
                    load      = 1'b1;
                    load_byte = pend_byte;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && (bit_cnt == 3'd7)) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Decoded straight from state so reset forces the line high without a clock
        TX       = (state != START) && ((state != DATA) || shreg[0]);
        tx_busy  = (state != IDLE);
        cmd_done = (state == STOP) && bit_end;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Baud and bit counters; both parked at zero outside their active phases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
        end else begin
            if (state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state != DATA) begin
                bit_cnt <= 3'd0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Shift register: loaded at frame start, shifted right at each data bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= 8'h00;
            cur_byte <= 8'h00;
        end else if (load) begin
            shreg    <= load_byte;
            cur_byte <= load_byte;
        end else if (state == DATA && bit_end) begin
            shreg    <= shreg >> 1;
        end
    end

    // Pending slot: latest request wins while busy; consumed whenever a frame starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_byte  <= 8'h00;
        end else if (state == IDLE) begin
            if (load) pend_valid <= 1'b0;
        end else if (req) begin
            pend_valid <= 1'b1;
            pend_byte  <= req_byte;
        end
    end

    // Record the byte of each frame that completes its stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_cmd <= 8'h00;
        end else if (cmd_done) begin
            last_cmd <= cur_byte;
        end
    end

endmodule
